// File: rtl/dac_spi_tx.sv
// Round-robin two-channel SPI transmitter for a dual 12-bit DAC (MCP4922-class).
// One pending word per channel; each word goes out as a 16-bit mode-0 frame with the channel/config header.
module dac_spi_tx #(
  parameter int   CLK_DIV  = 2,
  parameter int   CS_GAP   = 2,
  parameter logic DAC_BUF  = 1'b1,
  parameter logic DAC_GA_N = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] dac0,
  input  logic        dac0_dv,
  input  logic [11:0] dac1,
  input  logic        dac1_dv,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_cs_n,
  output logic        busy,
  output logic        frame_done,
  output logic        dac0_ovf,
  output logic        dac1_ovf
);

  localparam int NUM_CH = 2;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W  = (CS_GAP  > 1) ? $clog2(CS_GAP)  : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(CS_GAP - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SETUP = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]              state;
  logic [DIV_W-1:0]        div_cnt;
  logic [GAP_W-1:0]        gap_cnt;
  logic [3:0]              bit_cnt;
  logic [14:0]             shreg;
  logic                    last_ch;

  logic [NUM_CH-1:0][11:0] din, dq;
  logic [NUM_CH-1:0]       dv, clr, pend, ovf;
  logic                    win, load_go;
  logic [15:0]             frame;

  assign din = {dac1, dac0};
  assign dv  = {dac1_dv, dac0_dv};

  // Clearing happens on the IDLE->LOAD edge; a dv on that same edge keeps the new word pending.
  assign load_go = (state == S_IDLE) && (|pend);
  assign clr     = {load_go & win, load_go & ~win};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [11:0] q;
    logic        p, o;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= '0;
        p <= 1'b0;
        o <= 1'b0;
      end else begin
        o <= dv[c] & p & ~clr[c];
        if (dv[c]) begin
          q <= din[c];
          p <= 1'b1;
        end else if (clr[c]) begin
          p <= 1'b0;
        end
      end
    end
    assign dq[c]   = q;
    assign pend[c] = p;
    assign ovf[c]  = o;
  end

  assign dac0_ovf = ovf[0];
  assign dac1_ovf = ovf[1];

  always_comb begin
    win = pend[1];
    if (&pend) win = ~last_ch;
  end

  assign frame = {win, DAC_BUF, DAC_GA_N, 1'b1, dq[win]};
  assign busy  = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      div_cnt    <= '0;
      gap_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      last_ch    <= 1'b1;
      spi_sclk   <= 1'b0;
      spi_mosi   <= 1'b0;
      spi_cs_n   <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_go) begin
            state    <= S_LOAD;
            shreg    <= frame[14:0];
            spi_mosi <= frame[15];
            spi_cs_n <= 1'b0;
            bit_cnt  <= 4'd15;
            last_ch  <= win;
          end
        end
        S_LOAD: begin
          state   <= S_SETUP;
          div_cnt <= DIV_MAX;
        end
        S_SETUP: begin
          if (div_cnt == '0) begin
            state    <= S_SHIFT;
            spi_sclk <= 1'b1;
            div_cnt  <= DIV_MAX;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        S_SHIFT: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
          end else begin
            div_cnt <= DIV_MAX;
            if (spi_sclk) begin
              // Data advances on the falling edge; the last bit holds through its low phase.
              spi_sclk <= 1'b0;
              if (bit_cnt != 4'd0) begin
                spi_mosi <= shreg[14];
                shreg    <= {shreg[13:0], 1'b0};
              end
            end else if (bit_cnt == 4'd0) begin
              state      <= S_GAP;
              spi_cs_n   <= 1'b1;
              spi_mosi   <= 1'b0;
              frame_done <= 1'b1;
              gap_cnt    <= GAP_MAX;
            end else begin
              bit_cnt  <= bit_cnt - 1'b1;
              spi_sclk <= 1'b1;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) state <= S_IDLE;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: decodes SPI frames from the pins and checks them against hand-computed words.
module tb_dac_spi_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] dac0, dac1;
  logic        dac0_dv, dac1_dv;
  logic        spi_sclk, spi_mosi, spi_cs_n, busy, frame_done, dac0_ovf, dac1_ovf;

  dac_spi_tx #(.CLK_DIV(2), .CS_GAP(2), .DAC_BUF(1'b1), .DAC_GA_N(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .dac0(dac0), .dac0_dv(dac0_dv), .dac1(dac1), .dac1_dv(dac1_dv),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
    .busy(busy), .frame_done(frame_done), .dac0_ovf(dac0_ovf), .dac1_ovf(dac1_ovf)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Pin-level frame decoder, sampled on the falling clk edge.
  logic [15:0] frm_q[$];
  int          low_q[$], rise_q[$], gap_q[$];
  int          n_fd = 0, n_fd_al = 0, n_ovf0 = 0, n_ovf1 = 0, n_fall = 0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0, in_frm = 1'b0, seen_rise = 1'b0;
  logic [15:0] sh;
  int          nb, lo, hi_cnt;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frm    = 1'b0;
      seen_rise = 1'b0;
    end else begin
      if (prev_cs && !spi_cs_n) begin
        n_fall++;
        if (seen_rise) gap_q.push_back(hi_cnt);
        in_frm = 1'b1; sh = '0; nb = 0; lo = 0;
      end
      if (!spi_cs_n) begin
        lo++;
        if (!prev_sclk && spi_sclk) begin
          sh = {sh[14:0], spi_mosi};
          nb++;
        end
      end
      if (!prev_cs && spi_cs_n && in_frm) begin
        frm_q.push_back(sh); low_q.push_back(lo); rise_q.push_back(nb);
        in_frm = 1'b0; seen_rise = 1'b1; hi_cnt = 0;
        if (frame_done) n_fd_al++;
      end
      if (spi_cs_n) hi_cnt++;
      if (frame_done) n_fd++;
      if (dac0_ovf) n_ovf0++;
      if (dac1_ovf) n_ovf1++;
    end
    prev_cs   = spi_cs_n;
    prev_sclk = spi_sclk;
  end

  task automatic strobe(input logic s0, input logic s1, input logic [11:0] d0, input logic [11:0] d1);
    @(posedge clk); #1;
    dac0 = d0; dac1 = d1; dac0_dv = s0; dac1_dv = s1;
    @(posedge clk); #1;
    dac0_dv = 1'b0; dac1_dv = 1'b0;
  endtask

  task automatic wait_frames(input string tag, input int n, input int budget);
    int c = 0;
    while (frm_q.size() < n && c < budget) begin
      @(posedge clk); c++;
    end
    chk(tag, frm_q.size(), n);
  endtask

  task automatic wait_quiet(input string tag);
    int c = 0, q = 0;
    while (q < 5 && c < 2000) begin
      @(posedge clk); #1; c++;
      q = busy ? 0 : q + 1;
    end
    chk(tag, q, 5);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    int b, g, f, o0, o1, nr, c;
    logic ps;
    rst_n = 1'b0; dac0 = '0; dac1 = '0; dac0_dv = 1'b0; dac1_dv = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_sclk", spi_sclk, 1'b0);
    chk("rst_mosi", spi_mosi, 1'b0);
    chk("rst_cs_n", spi_cs_n, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fd",   frame_done, 1'b0);
    chk("rst_ovf",  {dac0_ovf, dac1_ovf}, 2'b00);
    @(negedge clk); rst_n = 1'b1;

    // Single write, latency and frame shape
    b = frm_q.size(); f = n_fd;
    strobe(1'b1, 1'b0, 12'hABC, 12'h000);
    chk("lat_cs_hi", spi_cs_n, 1'b1);
    @(posedge clk); #1;
    chk("lat_cs_lo", spi_cs_n, 1'b0);
    chk("lat_busy", busy, 1'b1);
    wait_frames("single_n", b + 1, 300);
    chk("single_frm", frm_q[b], 16'h7ABC);
    chk("single_low", low_q[b], 67);
    chk("single_rise", rise_q[b], 16);
    wait_quiet("single_quiet");
    chk("single_fd", n_fd - f, 1);
    chk("single_fd_al", n_fd_al, 1);

    // Simultaneous writes after reset
    do_reset();
    b = frm_q.size(); g = gap_q.size(); o0 = n_ovf0; o1 = n_ovf1;
    strobe(1'b1, 1'b1, 12'h123, 12'h456);
    wait_frames("simul_n", b + 2, 400);
    chk("simul_f0", frm_q[b], 16'h7123);
    chk("simul_f1", frm_q[b + 1], 16'hF456);
    chk("simul_gap", gap_q[g], 3);
    chk("simul_ovf", {n_ovf0 - o0, n_ovf1 - o1}, 64'd0);
    wait_quiet("simul_quiet");

    // Overflow on dac0 while dac1 is shifting
    b = frm_q.size(); o0 = n_ovf0; o1 = n_ovf1;
    strobe(1'b0, 1'b1, 12'h000, 12'h0F0);
    repeat (10) @(posedge clk);
    strobe(1'b1, 1'b0, 12'h111, 12'h000);
    repeat (5) @(posedge clk);
    strobe(1'b1, 1'b0, 12'h222, 12'h000);
    wait_frames("ovf_n", b + 2, 400);
    chk("ovf_f0", frm_q[b], 16'hF0F0);
    chk("ovf_f1", frm_q[b + 1], 16'h7222);
    chk("ovf_cnt0", n_ovf0 - o0, 1);
    chk("ovf_cnt1", n_ovf1 - o1, 0);
    wait_quiet("ovf_quiet");

    // Fairness: last frame was dac0, so dac1 goes first
    b = frm_q.size(); c = 0;
    while (frm_q.size() < b + 6 && c < 100) begin
      strobe(1'b1, 1'b1, 12'(c), 12'(c + 12'h100));
      repeat (8) @(posedge clk);
      c++;
    end
    chk("fair_n", frm_q.size(), b + 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("fair_hdr%0d", i), 32'(frm_q[b + i][15:12]), (i % 2 == 0) ? 32'hF : 32'h7);
    wait_quiet("fair_quiet");

    // Reset at the 8th sclk rise
    b = frm_q.size(); f = n_fall;
    strobe(1'b1, 1'b0, 12'h333, 12'h000);
    nr = 0; c = 0; ps = spi_sclk;
    while (nr < 8 && c < 300) begin
      @(negedge clk); c++;
      if (!ps && spi_sclk) nr++;
      ps = spi_sclk;
    end
    chk("mrst_rises", nr, 8);
    rst_n = 1'b0; #1;
    chk("mrst_cs_n", spi_cs_n, 1'b1);
    chk("mrst_sclk", spi_sclk, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    f = n_fall;
    repeat (100) @(posedge clk); #1;
    chk("mrst_nofall", n_fall - f, 0);
    chk("mrst_nofrm", frm_q.size(), b);
    chk("mrst_idle", busy, 1'b0);

    // Dv on dac0 while its own frame shifts
    b = frm_q.size(); o0 = n_ovf0;
    strobe(1'b1, 1'b0, 12'h0AA, 12'h000);
    repeat (20) @(posedge clk);
    strobe(1'b1, 1'b0, 12'h5A5, 12'h000);
    wait_frames("own_n", b + 2, 400);
    chk("own_f0", frm_q[b], 16'h70AA);
    chk("own_f1", frm_q[b + 1], 16'h75A5);
    chk("own_ovf", n_ovf0 - o0, 0);
    wait_quiet("own_quiet");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
